// File: rtl/spi_uart_burst_bridge.sv
// spi_uart_burst_bridge: reads a burst of consecutive 7-bit-addressed registers
// from an SPI slave (mode 0), buffers the bytes in a small synchronous FIFO and
// streams them out on a UART 8N1 transmitter. busy spans the whole request;
// done pulses once the final stop bit has left the line.
module spi_uart_burst_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SPI_DIV      = 4,
    parameter int FIFO_AW      = 4,
    parameter int LEN_W        = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       base_addr,
    input  logic [LEN_W-1:0] len,
    output logic             spi_clk,
    output logic             spi_cs,
    input  logic             spi_in,
    output logic             spi_out,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam int DIV_W  = (SPI_DIV > 2) ? $clog2(SPI_DIV) : 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SPI_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        SPI_IDLE,
        SPI_WAIT_ROOM,
        SPI_CS_SETUP,
        SPI_SHIFT,
        SPI_CS_HOLD,
        SPI_GAP
    } spi_state_t;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    // SPI engine state
    spi_state_t       spi_state;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [14:0]      frame_sr;
    logic [7:0]       rx_sr;
    logic [6:0]       addr;
    logic [LEN_W-1:0] remaining;

    // FIFO storage and pointers (extra MSB separates full from empty)
    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wptr;
    logic [FIFO_AW:0] rptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [7:0]       rdata;

    // UART transmitter state
    uart_state_t       uart_state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        tx_sr;

    logic start_ok;
    logic done_cond;

    assign start_ok   = start && !busy && (len != '0);
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                        (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign rdata      = mem[rptr[FIFO_AW-1:0]];
    assign push       = (spi_state == SPI_CS_HOLD) && (div_cnt == DIV_LAST);
    assign pop        = (uart_state == UART_IDLE) && !fifo_empty;
    assign done_cond  = busy && (spi_state == SPI_IDLE) && (remaining == '0) &&
                        fifo_empty && (uart_state == UART_STOP) &&
                        (baud_cnt == BAUD_LAST);

    // Request acceptance and completion: busy spans the burst, done marks its end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                busy <= 1'b1;
            end else if (done_cond) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    // SPI master: one 16-bit read frame per register, waiting for FIFO room first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_state <= SPI_IDLE;
            spi_cs    <= 1'b1;
            spi_clk   <= 1'b0;
            spi_out   <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            frame_sr  <= '0;
            rx_sr     <= '0;
            addr      <= '0;
            remaining <= '0;
        end else begin
            case (spi_state)
                SPI_IDLE: begin
                    if (start_ok) begin
                        addr      <= base_addr;
                        remaining <= len;
                        spi_state <= SPI_WAIT_ROOM;
                    end
                end
                SPI_WAIT_ROOM: begin
                    if (!fifo_full) begin
                        spi_cs    <= 1'b0;
                        spi_out   <= 1'b1;
                        frame_sr  <= {addr, 8'h00};
                        div_cnt   <= '0;
                        spi_state <= SPI_CS_SETUP;
                    end
                end
                SPI_CS_SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        spi_clk   <= 1'b1;
                        rx_sr     <= {rx_sr[6:0], spi_in};
                        bit_cnt   <= '0;
                        spi_state <= SPI_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SPI_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (spi_clk) begin
                            spi_clk <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                spi_out   <= 1'b0;
                                spi_state <= SPI_CS_HOLD;
                            end else begin
                                spi_out  <= frame_sr[14];
                                frame_sr <= {frame_sr[13:0], 1'b0};
                                bit_cnt  <= bit_cnt + 1'b1;
                            end
                        end else begin
                            spi_clk <= 1'b1;
                            rx_sr   <= {rx_sr[6:0], spi_in};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SPI_CS_HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        spi_cs    <= 1'b1;
                        spi_state <= SPI_GAP;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SPI_GAP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        addr      <= addr + 7'd1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            spi_state <= SPI_IDLE;
                        end else begin
                            spi_state <= SPI_WAIT_ROOM;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    spi_state <= SPI_IDLE;
                end
            endcase
        end
    end

    // FIFO storage: written on the cycle the SPI frame closes
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[FIFO_AW-1:0]] <= rx_sr;
        end
    end

    // FIFO pointers: a push into an empty FIFO becomes visible one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // UART 8N1 transmitter: pops a byte when idle and shifts it out LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_state <= UART_IDLE;
            tx         <= 1'b1;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            tx_sr      <= '0;
        end else begin
            case (uart_state)
                UART_IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        tx_sr      <= rdata;
                        tx         <= 1'b0;
                        baud_cnt   <= '0;
                        uart_state <= UART_START;
                    end
                end
                UART_START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt   <= '0;
                        tx         <= tx_sr[0];
                        bit_idx    <= '0;
                        uart_state <= UART_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                UART_DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx         <= 1'b1;
                            uart_state <= UART_STOP;
                        end else begin
                            tx      <= tx_sr[1];
                            tx_sr   <= {1'b0, tx_sr[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                UART_STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt   <= '0;
                        uart_state <= UART_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    uart_state <= UART_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_uart_burst_bridge.sv
// Directed bench for spi_uart_burst_bridge: behavioural SPI slave, UART
// receiver and line monitors, with a linear sequence of checked steps.
`timescale 1ns/1ps
module tb_spi_uart_burst_bridge;

    localparam int CPB = 20;
    localparam int DIV = 4;
    localparam int AW  = 2;
    localparam int LW  = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [6:0]    base_addr = '0;
    logic [LW-1:0] len = '0;
    logic          spi_clk, spi_cs, spi_out, tx, busy, done;
    logic          miso = 1'b0;

    int checks = 0;
    int failures = 0;

    spi_uart_burst_bridge #(
        .CLKS_PER_BIT(CPB),
        .SPI_DIV(DIV),
        .FIFO_AW(AW),
        .LEN_W(LW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_addr(base_addr),
        .len(len),
        .spi_clk(spi_clk),
        .spi_cs(spi_cs),
        .spi_in(miso),
        .spi_out(spi_out),
        .tx(tx),
        .busy(busy),
        .done(done)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    // Register contents of the emulated sensor
    function automatic logic [7:0] slave_byte(input int a);
        if (a == 16) return 8'hA5;
        return 8'((a * 3 + 7) & 255);
    endfunction

    function automatic logic [15:0] read_frame(input int a);
        logic [6:0] a7;
        a7 = 7'(a);
        return {1'b1, a7, 8'h00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // SPI slave, mode 0: latches MOSI on rising SCK, drives MISO on falling SCK
    logic [15:0] s_in = '0;
    logic [7:0]  s_data = '0;
    int          s_cnt = 0;
    logic [15:0] frame_q[$];
    int          short_frames = 0;

    always @(negedge spi_cs) begin
        s_cnt = 0;
        s_in = '0;
        miso = 1'b0;
    end

    always @(posedge spi_clk) begin
        if (spi_cs === 1'b0) begin
            s_in = {s_in[14:0], spi_out};
            s_cnt++;
        end
    end

    always @(negedge spi_clk) begin
        if (spi_cs === 1'b0) begin
            if (s_cnt == 8) begin
                s_data = slave_byte(int'(s_in[6:0]));
                miso = s_data[7];
            end else if (s_cnt > 8) begin
                s_data = {s_data[6:0], 1'b0};
                miso = s_data[7];
            end
        end
    end

    always @(posedge spi_cs) begin
        if (rst_n === 1'b1) begin
            frame_q.push_back(s_in);
            if (s_cnt != 16) short_frames++;
        end
    end

    // UART receiver sampling mid-bit
    logic [7:0] rx_q[$];
    int         rx_starts = 0;
    int         frame_err = 0;

    always begin : uart_rx
        logic [7:0] b;
        @(negedge clk);
        if (rst_n === 1'b1 && tx === 1'b0) begin
            rx_starts++;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) frame_err++;
            rx_q.push_back(b);
        end
    end

    // Line monitor: SCK phase lengths, done pulses, FIFO occupancy bound
    int   hi_len = 0, lo_len = 0, hi_bad = 0, lo_bad = 0, hi_runs = 0;
    int   cs_falls = 0, max_diff = 0, done_pulses = 0;
    logic prev_cs = 1'b1;
    logic seen_rise = 1'b0;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            prev_cs = 1'b1;
            hi_len = 0;
            lo_len = 0;
            seen_rise = 1'b0;
        end else begin
            if (done === 1'b1) done_pulses++;
            if (prev_cs === 1'b1 && spi_cs === 1'b0) begin
                cs_falls++;
                if (cs_falls - rx_starts > max_diff) max_diff = cs_falls - rx_starts;
            end
            if (spi_cs !== 1'b0) begin
                hi_len = 0;
                lo_len = 0;
                seen_rise = 1'b0;
            end else if (spi_clk === 1'b1) begin
                if (lo_len > 0 && seen_rise && lo_len != DIV) lo_bad++;
                lo_len = 0;
                hi_len++;
                seen_rise = 1'b1;
            end else begin
                if (hi_len > 0) begin
                    hi_runs++;
                    if (hi_len != DIV) hi_bad++;
                end
                hi_len = 0;
                lo_len++;
            end
            prev_cs = spi_cs;
        end
    end

    task automatic pulse_start(input logic [6:0] a, input logic [LW-1:0] n);
        base_addr = a;
        len = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Global watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    // Directed test sequence
    initial begin
        int f0, r0, d0, h0, c0;
        bit ok;
        logic [9:0] line_bits;
        logic [6:0] a;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_spi_cs", spi_cs, 1'b1);
        check("rst_spi_clk", spi_clk, 1'b0);
        check("rst_spi_out", spi_out, 1'b0);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single read of 0xA5 at 0x10, exact bit timing on tx
        f0 = frame_q.size(); r0 = rx_q.size(); d0 = done_pulses; h0 = hi_runs;
        pulse_start(7'h10, 7'd1);
        check("single_busy_set", busy, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("single_tx_start_seen", ok, 1'b1);
        line_bits = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            check($sformatf("single_bit%0d_first", k), tx, line_bits[k]);
            repeat (CPB - 1) @(negedge clk);
            check($sformatf("single_bit%0d_last", k), tx, line_bits[k]);
            @(negedge clk);
        end
        check("single_done_pulse", done, 1'b1);
        check("single_busy_clear", busy, 1'b0);
        @(negedge clk);
        check("single_done_one_cycle", done, 1'b0);
        repeat (3) @(negedge clk);
        check("single_frames", frame_q.size() - f0, 1);
        check("single_mosi_frame", frame_q[f0], 16'h9000);
        check("single_bytes", rx_q.size() - r0, 1);
        check("single_byte", rx_q[r0], 8'hA5);
        check("single_done_count", done_pulses - d0, 1);
        check("single_sck_pulses", hi_runs - h0, 16);
        check("sck_high_len_bad", hi_bad, 0);
        check("sck_low_len_bad", lo_bad, 0);

        // Burst crossing the 0x7F -> 0x00 address wrap
        f0 = frame_q.size(); r0 = rx_q.size(); d0 = done_pulses;
        pulse_start(7'h7E, 7'd4);
        wait_done(6000, ok);
        check("wrap_done_seen", ok, 1'b1);
        repeat (3) @(negedge clk);
        check("wrap_frames", frame_q.size() - f0, 4);
        check("wrap_bytes", rx_q.size() - r0, 4);
        for (int i = 0; i < 4; i++) begin
            a = 7'h7E + 7'(i);
            check($sformatf("wrap_frame%0d", i), frame_q[f0 + i], read_frame(int'(a)));
            check($sformatf("wrap_byte%0d", i), rx_q[r0 + i], slave_byte(int'(a)));
        end
        check("wrap_done_count", done_pulses - d0, 1);

        // Backpressure: 20 bytes through a 4-deep FIFO
        f0 = frame_q.size(); r0 = rx_q.size(); d0 = done_pulses;
        pulse_start(7'h05, 7'd20);
        wait_done(8000, ok);
        check("bp_done_seen", ok, 1'b1);
        repeat (3) @(negedge clk);
        check("bp_frames", frame_q.size() - f0, 20);
        check("bp_bytes", rx_q.size() - r0, 20);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("bp_byte%0d", i), rx_q[r0 + i], slave_byte(5 + i));
        end
        check("bp_max_occupancy", max_diff, 4);
        check("bp_done_count", done_pulses - d0, 1);
        check("uart_stop_errors", frame_err, 0);

        // Ignored requests: len=0, then a second start while busy
        c0 = cs_falls;
        pulse_start(7'h33, 7'd0);
        repeat (20) @(negedge clk);
        check("len0_busy", busy, 1'b0);
        check("len0_no_frame", cs_falls - c0, 0);
        f0 = frame_q.size(); r0 = rx_q.size(); d0 = done_pulses;
        pulse_start(7'h20, 7'd3);
        repeat (50) @(negedge clk);
        pulse_start(7'h50, 7'd5);
        wait_done(4000, ok);
        check("ign_done_seen", ok, 1'b1);
        repeat (300) @(negedge clk);
        check("ign_frames", frame_q.size() - f0, 3);
        check("ign_bytes", rx_q.size() - r0, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ign_frame%0d", i), frame_q[f0 + i], read_frame(32 + i));
            check($sformatf("ign_byte%0d", i), rx_q[r0 + i], slave_byte(32 + i));
        end
        check("ign_done_count", done_pulses - d0, 1);
        check("ign_busy_idle", busy, 1'b0);

        // Reset during the high phase of SCK bit 9
        pulse_start(7'h30, 7'd2);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (spi_cs === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rstmid_cs_seen", ok, 1'b1);
        repeat (4 + 8 * 9 + 2) @(negedge clk);
        check("rstmid_in_bit9_high", spi_clk, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_spi_cs", spi_cs, 1'b1);
        check("rstmid_spi_clk", spi_clk, 1'b0);
        check("rstmid_spi_out", spi_out, 1'b0);
        check("rstmid_tx", tx, 1'b1);
        check("rstmid_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rstmid_busy_after", busy, 1'b0);
        check("rstmid_tx_after", tx, 1'b1);
        f0 = frame_q.size(); r0 = rx_q.size(); d0 = done_pulses;
        pulse_start(7'h40, 7'd2);
        wait_done(4000, ok);
        check("post_done_seen", ok, 1'b1);
        repeat (3) @(negedge clk);
        check("post_frames", frame_q.size() - f0, 2);
        check("post_bytes", rx_q.size() - r0, 2);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("post_frame%0d", i), frame_q[f0 + i], read_frame(64 + i));
            check($sformatf("post_byte%0d", i), rx_q[r0 + i], slave_byte(64 + i));
        end
        check("post_done_count", done_pulses - d0, 1);
        check("final_sck_high_bad", hi_bad, 0);
        check("final_sck_low_bad", lo_bad, 0);
        check("short_frames", short_frames, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_uart_burst_bridge.md
Name: spi_uart_burst_bridge

Overview:
Parametrised successor to the single-register SPI-to-UART path. On a start pulse it reads a burst of consecutive 7-bit-addressed registers from an SPI slave and buffers each byte in an internal FIFO. The buffered bytes stream out on a UART 8N1 transmitter. It sits between a sensor-style SPI peripheral and the board UART, and includes its own SPI master engine, synchronous FIFO and UART TX.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200).
SPI_DIV, 4, clk cycles per SCK half-period (>=2).
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW.
LEN_W, 7, width of the burst-length input.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; asynchronous, active-low
start  input  1  single-cycle burst request; sampled only when busy=0
base_addr  input  7  first register address of the burst
len  input  LEN_W  bytes to read; 0 = request ignored
spi_clk  output  1  SCK, idle low (mode 0)
spi_cs  output  1  chip select, active low
spi_in  input  1  MISO
spi_out  output  1  MOSI
tx  output  1  UART serial out, idle high
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when burst fully transmitted

Behaviour:
- Reset (async assert, sync release): spi_cs=1, spi_clk=0, spi_out=0, tx=1, busy=0, done=0. FIFO empty, all FSMs idle, counters 0. Assertion mid-burst aborts immediately; no partial frame resumes after release.
- Start: start=1 with busy=0 and len!=0 latches base_addr and len, and sets busy on the next edge. Start while busy=1, or with len=0, is ignored with no side effects.
- SPI FSM states: IDLE, WAIT_ROOM, CS_SETUP, SHIFT, CS_HOLD, GAP.
  - IDLE->WAIT_ROOM on accepted start.
  - WAIT_ROOM: stays until the FIFO is not full, then goes to CS_SETUP. Flow control means no overflow is possible.
  - CS_SETUP: spi_cs=0 for SPI_DIV clocks, with spi_out = bit15 of the frame.
  - SHIFT: 16-bit frame, MSB first. Bit15 = 1 (read); bits14:8 = current addr; bits7:0 = don't-care, driven 0. There are 16 SCK pulses. MISO is sampled on each rising SCK edge; MOSI changes on each falling edge. The data byte is the last 8 sampled bits.
  - CS_HOLD: SPI_DIV clocks with SCK low, then spi_cs=1. The byte is pushed into the FIFO in the same cycle.
  - GAP: spi_cs high for SPI_DIV clocks. Then the address increments modulo 128 (0x7F wraps to 0x00) and the remaining count decrements. If remaining > 0, go to WAIT_ROOM; else go to IDLE.
- FIFO: synchronous, depth 2**FIFO_AW, with FIFO_AW+1-bit pointers for the full/empty distinction. Simultaneous push and pop when full is impossible, because the SPI side only pushes after checking room. Simultaneous push and pop when empty: the pushed byte is not visible until the next cycle.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty, pop one byte and go to START.
  - START: tx=0 for CLKS_PER_BIT clocks.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT clocks.
  - STOP: tx=1 for CLKS_PER_BIT clocks. Then go to IDLE, and may pop the next byte on the following cycle (1 clock inter-frame gap).
- done: pulses for one cycle when all of these hold: SPI FSM in IDLE with remaining=0, FIFO empty, UART FSM returning from STOP to IDLE. busy clears in the same cycle.
- SCK timing: one full SCK period = 2*SPI_DIV clocks. Total SPI frame ≈ (2 + 32 + 1)*SPI_DIV clocks.

Test Plan:
- Single read: slave returns 0xA5 at addr 0x10; start, base_addr=0x10, len=1 → MOSI frame 0x9000; tx shows start bit, bits 1,0,1,0,0,1,0,1, stop bit; done pulses once; busy 1→0.
- Burst with wrap: base_addr=0x7E, len=4 → address fields 0x7E, 0x7F, 0x00, 0x01 in order; 4 UART bytes match the slave contents at those addresses, in order.
- Backpressure: FIFO_AW=2, len=20, CLKS_PER_BIT=434 → FIFO never exceeds 4 entries; spi_cs stays high while full; all 20 bytes arrive intact; no byte lost or duplicated.
- Ignored requests: start with len=0 → busy stays 0; start pulsed mid-burst with a different base_addr → burst continues on the original addresses and length.
- Reset mid-frame: assert rst_n low during SHIFT bit 9 → spi_cs=1, spi_clk=0, tx=1 immediately; after release, busy=0 and FIFO empty; a new start len=2 behaves normally.
- Timing check: SPI_DIV=4 → SCK high and low phases each exactly 4 clocks; CLKS_PER_BIT=434 → each tx bit lasts exactly 434 clocks.
